// File: rtl/cordic_fu_ctrl.sv
// Sequencer for the iterative CORDIC functional unit. It accepts one operation
// per issue handshake and steps the shift-add datapath through NR_ITER
// iterations. It then holds the result on the shared writeback port until that
// port is granted. Only one operation is in flight at a time; flush kills it.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | ready for issue; op/ID latched on handshake
// LOAD   | one-cycle operand load strobe to the datapath
// ITER   | one datapath iteration per cycle, index from the counter
// WB     | result (or exception) presented until wb_ready_i
module cordic_fu_ctrl #(
  parameter int unsigned NR_ITER       = 16,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned OP_W          = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       cordic_valid_i,
  output logic                       cordic_ready_o,
  input  logic [OP_W-1:0]            op_i,
  input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
  output logic                       dp_load_o,
  output logic                       dp_en_o,
  output logic [$clog2(NR_ITER)-1:0] dp_iter_o,
  output logic [OP_W-1:0]            dp_op_o,
  input  logic [XLEN-1:0]            dp_result_i,
  output logic                       result_valid_o,
  input  logic                       wb_ready_i,
  output logic [XLEN-1:0]            result_o,
  output logic [TRANS_ID_BITS-1:0]   trans_id_o,
  output logic                       ex_valid_o
);

  localparam int unsigned IW = $clog2(NR_ITER);
  localparam logic [IW-1:0]   LAST_ITER = IW'(NR_ITER - 1);
  localparam logic [OP_W-1:0] OP_RSVD   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              cnt_q, cnt_d;
  logic [OP_W-1:0]            op_q, op_d;
  logic [TRANS_ID_BITS-1:0]   id_q, id_d;
  logic                       ex_q, ex_d;
  logic                       issue;

  // Ready is the only output allowed to see an input combinationally (flush).
  assign cordic_ready_o = (state_q == S_IDLE) & ~flush_i;
  assign issue          = cordic_valid_i & cordic_ready_o;

  // State and datapath-control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      id_q    <= '0;
      ex_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      id_q    <= id_d;
      ex_q    <= ex_d;
    end
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    id_d    = id_q;
    ex_d    = ex_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          op_d = op_i;
          id_d = trans_id_i;
          if (op_i == OP_RSVD) begin
            ex_d    = 1'b1;
            state_d = S_WB;
          end else begin
            ex_d    = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      S_WB: begin
        if (wb_ready_i) begin
          ex_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ex_d    = 1'b0;
    end
  end

  // Datapath and writeback outputs decoded from registered state only.
  assign dp_load_o      = (state_q == S_LOAD);
  assign dp_en_o        = (state_q == S_ITER);
  assign dp_iter_o      = cnt_q;
  assign dp_op_o        = op_q;
  assign result_valid_o = (state_q == S_WB);
  assign ex_valid_o     = (state_q == S_WB) & ex_q;
  assign trans_id_o     = id_q;
  assign result_o       = ((state_q == S_WB) && !ex_q) ? dp_result_i : '0;

endmodule
